// File: rtl/adpll_pkg.sv
// Shared types and defaults for the ADPLL loop stages.
package adpll_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StTrack  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DecNone = 2'd0,
    DecUp   = 2'd1,
    DecDn   = 2'd2
  } dec_t;

  localparam int unsigned DefCodeW   = 8;
  localparam int unsigned DefLockCnt = 16;

endpackage

// File: rtl/adpll_sync2.sv
// Two-flop synchroniser; with EDGE set, adds a third flop and a registered rising-edge pulse.
module adpll_sync2 #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

  if (EDGE) begin : g_edge
    logic s3_q, rise_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s3_q   <= 1'b0;
        rise_q <= 1'b0;
      end else begin
        s3_q   <= s2_q;
        rise_q <= s2_q & ~s3_q;
      end
    end

    assign rise = rise_q;
  end else begin : g_no_edge
    assign rise = 1'b0;
  end

endmodule

// File: rtl/dco_ctrl.sv
// ADPLL loop controller: binary-search acquisition of the DCO code, then unit-step tracking.
// The reference clock input is named ref_clk because "ref" is a reserved word.
module dco_ctrl
  import adpll_pkg::*;
#(
  parameter int unsigned CODE_W    = DefCodeW,
  parameter int unsigned CODE_INIT = 2 ** (CODE_W - 1),
  parameter int unsigned LOCK_CNT  = DefLockCnt
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ref_clk,
  input  logic              flagu,
  input  logic              flagd,
  output logic [CODE_W-1:0] dco_code,
  output logic              code_vld,
  output logic              lock,
  output logic [1:0]        state
);

  localparam logic [CODE_W-1:0] InitCode = CODE_W'(CODE_INIT);
  localparam logic [CODE_W-2:0] StepInit = {1'b1, {(CODE_W - 2){1'b0}}};
  localparam logic [CODE_W-2:0] StepOne  = (CODE_W - 1)'(1);
  localparam logic [7:0]        LockMax  = 8'(LOCK_CNT);

  logic ref_evt, fu_s, fd_s;
  logic ref_q_unused, fu_rise_unused, fd_rise_unused;

  adpll_sync2 #(.EDGE(1'b1)) u_sync_ref (
    .clk  (clk),
    .rst  (rst),
    .d    (ref_clk),
    .q    (ref_q_unused),
    .rise (ref_evt)
  );

  adpll_sync2 #(.EDGE(1'b0)) u_sync_fu (
    .clk  (clk),
    .rst  (rst),
    .d    (flagu),
    .q    (fu_s),
    .rise (fu_rise_unused)
  );

  adpll_sync2 #(.EDGE(1'b0)) u_sync_fd (
    .clk  (clk),
    .rst  (rst),
    .d    (flagd),
    .q    (fd_s),
    .rise (fd_rise_unused)
  );

  state_t              state_q, state_d;
  dec_t                prev_q, prev_d, dec;
  logic [CODE_W-1:0]   code_q, code_d, stepped, delta;
  logic [CODE_W-2:0]   step_q, step_d;
  logic [CODE_W:0]     sum;
  logic [7:0]          cnt_q, cnt_d;
  logic                up_seen_q, up_seen_d, dn_seen_q, dn_seen_d;
  logic                up_now, dn_now;
  logic                lock_q, vld_q;

  // A flag arriving in the ref_evt cycle still belongs to the period being closed.
  assign up_now = up_seen_q | fu_s;
  assign dn_now = dn_seen_q | fd_s;

  always_comb begin
    dec = DecNone;
    if (up_now && !dn_now) begin
      dec = DecUp;
    end else if (dn_now && !up_now) begin
      dec = DecDn;
    end
  end

  always_comb begin
    delta   = (state_q == StTrack) ? CODE_W'(1) : CODE_W'(step_q);
    sum     = {1'b0, code_q} + {1'b0, delta};
    stepped = code_q;
    case (dec)
      DecUp:   stepped = sum[CODE_W] ? '1 : sum[CODE_W-1:0];
      DecDn:   stepped = (code_q < delta) ? '0 : code_q - delta;
      default: stepped = code_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    step_d    = step_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    up_seen_d = ref_evt ? 1'b0 : up_now;
    dn_seen_d = ref_evt ? 1'b0 : dn_now;

    if (!en) begin
      state_d   = StIdle;
      code_d    = InitCode;
      step_d    = StepInit;
      prev_d    = DecNone;
      cnt_d     = '0;
      up_seen_d = 1'b0;
      dn_seen_d = 1'b0;
    end else if (ref_evt) begin
      case (state_q)
        StIdle: state_d = StSearch;
        StSearch: begin
          code_d = stepped;
          step_d = step_q >> 1;
          if (step_q == StepOne) begin
            state_d = StTrack;
            prev_d  = DecNone;
            cnt_d   = '0;
          end
        end
        StTrack: begin
          code_d = stepped;
          // Repeating the previous direction means we are still slewing, not dithering.
          if (dec != DecNone && dec == prev_q) begin
            cnt_d = '0;
          end else if (cnt_q != LockMax) begin
            cnt_d = cnt_q + 8'd1;
          end
          if (dec != DecNone) begin
            prev_d = dec;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      code_q    <= InitCode;
      step_q    <= StepInit;
      prev_q    <= DecNone;
      cnt_q     <= '0;
      up_seen_q <= 1'b0;
      dn_seen_q <= 1'b0;
      lock_q    <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      step_q    <= step_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      up_seen_q <= up_seen_d;
      dn_seen_q <= dn_seen_d;
      lock_q    <= en && (cnt_q == LockMax);
      vld_q     <= (code_d != code_q);
    end
  end

  assign dco_code = code_q;
  assign code_vld = vld_q;
  assign lock     = lock_q;
  assign state    = state_q;

endmodule

// File: tb/tb_dco_ctrl.sv
// Table-driven bench for dco_ctrl; code_vld pulses are checked against a queue of expected codes.
module tb_dco_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       ref_clk = 1'b0;
  logic       flagu = 1'b0;
  logic       flagd = 1'b0;
  logic [7:0] dco_code;
  logic       code_vld;
  logic       lock;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;
  int sb[$];
  int exp_code = 128;
  bit exp_lock = 1'b0;

  typedef struct {
    bit en;
    bit fu;
    bit fd;
    int code;
    int st;
    bit lk;
  } vec_t;

  vec_t tbl[$];

  dco_ctrl #(
    .CODE_W   (8),
    .CODE_INIT(128),
    .LOCK_CNT (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ref_clk (ref_clk),
    .flagu   (flagu),
    .flagd   (flagd),
    .dco_code(dco_code),
    .code_vld(code_vld),
    .lock    (lock),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && code_vld) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected_vld: got code_vld with code %0d, expected none (t=%0t)",
                 dco_code, $time);
      end else begin
        chk("sb_code", int'(dco_code), sb.pop_front());
      end
    end
  end

  function automatic void add(input bit e, input bit u, input bit d, input int c, input int s,
                              input bit l);
    vec_t v;
    v.en = e; v.fu = u; v.fd = d; v.code = c; v.st = s; v.lk = l;
    tbl.push_back(v);
  endfunction

  // One reference period: flags pulse, drain through the synchronisers, then a ref edge.
  task automatic run_vec(input vec_t v);
    if (!v.en) begin
      en = 1'b0; flagu = 1'b0; flagd = 1'b0;
      if (v.code != exp_code) sb.push_back(v.code);
      repeat (3) @(negedge clk);
      chk("dis_code", int'(dco_code), v.code);
      chk("dis_state", int'(state), v.st);
      chk("dis_lock", int'(lock), 0);
      ref_clk = 1'b1;
      repeat (8) @(negedge clk);
      chk("dis_ref_state", int'(state), 0);
      ref_clk = 1'b0;
      repeat (6) @(negedge clk);
      exp_code = v.code;
      exp_lock = 1'b0;
      return;
    end
    en = 1'b1; flagu = v.fu; flagd = v.fd;
    repeat (4) @(negedge clk);
    flagu = 1'b0; flagd = 1'b0;
    repeat (4) @(negedge clk);
    if (v.code != exp_code) sb.push_back(v.code);
    ref_clk = 1'b1;
    repeat (3) @(negedge clk);
    chk("code_latency", int'(dco_code), exp_code);
    @(negedge clk);
    chk("code", int'(dco_code), v.code);
    chk("code_vld", int'(code_vld), int'(v.code != exp_code));
    chk("lock_lag", int'(lock), int'(exp_lock));
    @(negedge clk);
    chk("lock", int'(lock), int'(v.lk));
    chk("state", int'(state), v.st);
    chk("vld_one_cycle", int'(code_vld), 0);
    repeat (4) @(negedge clk);
    ref_clk = 1'b0;
    repeat (6) @(negedge clk);
    exp_code = v.code;
    exp_lock = v.lk;
  endtask

  initial begin
    vec_t v;
    // Search upward, then saturate at the top in TRACK.
    add(1, 1, 0, 128, 1, 0);
    add(1, 1, 0, 192, 1, 0);
    add(1, 1, 0, 224, 1, 0);
    add(1, 1, 0, 240, 1, 0);
    add(1, 1, 0, 248, 1, 0);
    add(1, 1, 0, 252, 1, 0);
    add(1, 1, 0, 254, 1, 0);
    add(1, 1, 0, 255, 2, 0);
    add(1, 1, 0, 255, 2, 0);
    add(1, 1, 0, 255, 2, 0);
    add(0, 0, 0, 128, 0, 0);
    // Search downward, then saturate at zero.
    add(1, 0, 1, 128, 1, 0);
    add(1, 0, 1, 64, 1, 0);
    add(1, 0, 1, 32, 1, 0);
    add(1, 0, 1, 16, 1, 0);
    add(1, 0, 1, 8, 1, 0);
    add(1, 0, 1, 4, 1, 0);
    add(1, 0, 1, 2, 1, 0);
    add(1, 0, 1, 1, 2, 0);
    add(1, 0, 1, 0, 2, 0);
    add(1, 0, 1, 0, 2, 0);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) add(1, 1, 0, 1, 2, 0);
      else            add(1, 0, 1, 0, 2, i == 15);
    end
    add(1, 1, 0, 1, 2, 1);
    add(1, 1, 0, 2, 2, 0);
    add(1, 1, 1, 2, 2, 0);

    repeat (3) @(negedge clk);
    chk("rst_code", int'(dco_code), 128);
    chk("rst_vld", int'(code_vld), 0);
    chk("rst_lock", int'(lock), 0);
    chk("rst_state", int'(state), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) run_vec(tbl[i]);

    // en falls in the ref_evt cycle: no step, straight back to IDLE.
    en = 1'b1; flagu = 1'b1;
    repeat (4) @(negedge clk);
    flagu = 1'b0;
    repeat (4) @(negedge clk);
    sb.push_back(128);
    ref_clk = 1'b1;
    repeat (3) @(negedge clk);
    chk("evt_dis_pre_code", int'(dco_code), 2);
    en = 1'b0;
    @(negedge clk);
    chk("evt_dis_state", int'(state), 0);
    chk("evt_dis_code", int'(dco_code), 128);
    chk("evt_dis_vld", int'(code_vld), 1);
    chk("evt_dis_lock", int'(lock), 0);
    @(negedge clk);
    chk("evt_dis_state2", int'(state), 0);
    chk("evt_dis_code2", int'(dco_code), 128);
    ref_clk = 1'b0;
    repeat (6) @(negedge clk);
    exp_code = 128;
    exp_lock = 1'b0;

    v.en = 1; v.fu = 1; v.fd = 0; v.code = 128; v.st = 1; v.lk = 0;
    run_vec(v);
    v.code = 192;
    run_vec(v);

    // Asynchronous reset in the middle of a clock phase.
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_code", int'(dco_code), 128);
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_lock", int'(lock), 0);
    chk("mid_rst_vld", int'(code_vld), 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_code", int'(dco_code), 128);
    chk("post_rst_state", int'(state), 0);
    chk("post_rst_vld", int'(code_vld), 0);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
